// File: rtl/seq_multiplier_if.sv
// Start/busy/done handshake bundle for seq_multiplier.
// acc_add/acc are present only when MUL_ACCUM_EN is defined.
interface seq_multiplier_if #(
  parameter int WIDTH     = 16,
  parameter int ACC_GUARD = 4
);
  logic                          start;
  logic signed [WIDTH-1:0]       op_a;
  logic signed [WIDTH-1:0]       op_b;
  logic                          busy;
  logic                          done;
  logic signed [2*WIDTH-1:0]     product;
`ifdef MUL_ACCUM_EN
  logic                                acc_add;
  logic signed [2*WIDTH+ACC_GUARD-1:0] acc;

  modport master (output start, op_a, op_b, acc_add, input busy, done, product, acc);
  modport slave  (input start, op_a, op_b, acc_add, output busy, done, product, acc);
`else
  modport master (output start, op_a, op_b, input busy, done, product);
  modport slave  (input start, op_a, op_b, output busy, done, product);
`endif
endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 Booth sequential signed multiplier, one step per clock, WIDTH cycles to done.
// Define MUL_ACCUM_EN to add the product accumulator (acc_add/acc).
module seq_multiplier #(
  parameter int WIDTH     = 16,
  parameter int ACC_GUARD = 4
) (
  input logic            clk,
  input logic            rst_n,
  seq_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                state;
  logic [CW-1:0]             cnt;
  logic signed [WIDTH-1:0]   a_reg;
  logic signed [WIDTH:0]     p_reg;
  logic [WIDTH-1:0]          q_reg;
  logic                      q_m1;
  logic signed [2*WIDTH-1:0] product_reg;

  logic                      accept;
  logic                      finish;
  logic signed [WIDTH:0]     a_ext;
  logic signed [WIDTH:0]     sum;
  logic signed [WIDTH:0]     p_nxt;
  logic [WIDTH-1:0]          q_nxt;
  logic signed [2*WIDTH-1:0] prod_nxt;

  // DONE is not busy, so a start there issues back-to-back
  assign accept   = bus.start && (state != S_RUN);
  assign finish   = (state == S_RUN) && (cnt == CW'(1));
  assign a_ext    = {a_reg[WIDTH-1], a_reg};
  assign prod_nxt = {p_nxt[WIDTH-1:0], q_nxt};

  always_comb begin
    sum = p_reg;
    case ({q_reg[0], q_m1})
      2'b01:   sum = p_reg + a_ext;
      2'b10:   sum = p_reg - a_ext;
      default: sum = p_reg;
    endcase
    p_nxt = {sum[WIDTH], sum[WIDTH:1]};
    q_nxt = {sum[0], q_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      a_reg       <= '0;
      p_reg       <= '0;
      q_reg       <= '0;
      q_m1        <= 1'b0;
      product_reg <= '0;
    end else begin
      case (state)
        S_RUN: begin
          p_reg <= p_nxt;
          q_reg <= q_nxt;
          q_m1  <= q_reg[0];
          cnt   <= cnt - 1'b1;
          if (finish) begin
            product_reg <= prod_nxt;
            state       <= S_DONE;
          end
        end
        default: begin
          if (accept) begin
            a_reg <= bus.op_a;
            q_reg <= bus.op_b;
            p_reg <= '0;
            q_m1  <= 1'b0;
            cnt   <= CW'(WIDTH);
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy    = (state == S_RUN);
  assign bus.done    = (state == S_DONE);
  assign bus.product = product_reg;

`ifdef MUL_ACCUM_EN
  localparam int ACC_W = 2*WIDTH + ACC_GUARD;

  logic                    add_reg;
  logic signed [ACC_W-1:0] acc_reg;

  // Wraps modulo 2^ACC_W; no saturation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_reg <= 1'b0;
      acc_reg <= '0;
    end else begin
      if (accept) add_reg <= bus.acc_add;
      if (finish) acc_reg <= (add_reg ? acc_reg : '0) + ACC_W'(prod_nxt);
    end
  end

  assign bus.acc = acc_reg;
`endif
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed + random bench for seq_multiplier at WIDTH 16, 4 and 32 with a product scoreboard.
module tb_seq_multiplier;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_pass = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_multiplier_if #(.WIDTH(16), .ACC_GUARD(4)) bus16 ();
  seq_multiplier_if #(.WIDTH(4),  .ACC_GUARD(4)) bus4 ();
  seq_multiplier_if #(.WIDTH(32), .ACC_GUARD(4)) bus32 ();

  seq_multiplier #(.WIDTH(16), .ACC_GUARD(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  seq_multiplier #(.WIDTH(4),  .ACC_GUARD(4)) dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
  seq_multiplier #(.WIDTH(32), .ACC_GUARD(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  logic signed [31:0] exp16_q[$];
  int                 t16_q[$];
  logic signed [7:0]  exp4_q[$];
  logic signed [63:0] exp32_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue16(input logic signed [15:0] a, input logic signed [15:0] b);
    bus16.op_a  = a;
    bus16.op_b  = b;
    bus16.start = 1'b1;
    exp16_q.push_back(32'(int'(a) * int'(b)));
    t16_q.push_back(cyc + 1);
    @(negedge clk);
    bus16.start = 1'b0;
  endtask

  task automatic wait16(input string tag);
    logic signed [31:0] e;
    int t;
    for (int i = 0; i < 100 && bus16.done !== 1'b1; i++) @(negedge clk);
    chk({tag, " done"}, 64'(bus16.done), 64'(1));
    if (bus16.done === 1'b1 && exp16_q.size() > 0) begin
      e = exp16_q.pop_front();
      t = t16_q.pop_front();
      chk({tag, " latency"}, 64'(cyc - t), 64'(16));
      chk({tag, " product"}, bus16.product, e);
      chk({tag, " busy"}, 64'(bus16.busy), 64'(0));
    end
  endtask

  initial begin
    logic signed [3:0]  a4, b4;
    logic signed [31:0] a32, b32;
    int t, d1, seen;

    bus16.start = 1'b0; bus16.op_a = '0; bus16.op_b = '0;
    bus4.start  = 1'b0; bus4.op_a  = '0; bus4.op_b  = '0;
    bus32.start = 1'b0; bus32.op_a = '0; bus32.op_b = '0;
`ifdef MUL_ACCUM_EN
    bus16.acc_add = 1'b0; bus4.acc_add = 1'b0; bus32.acc_add = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst busy", 64'(bus16.busy), 64'(0));
    chk("rst done", 64'(bus16.done), 64'(0));
    chk("rst product", bus16.product, 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst busy", 64'(bus16.busy), 64'(0));
    chk("post-rst done", 64'(bus16.done), 64'(0));
    chk("post-rst product", bus16.product, 64'(0));
`ifdef MUL_ACCUM_EN
    chk("rst acc", bus16.acc, 64'(0));
`endif

    // Basic and corner operands
    issue16(16'sd3, -16'sd5);           wait16("3x-5");
    chk("3x-5 literal", bus16.product, 64'($signed(32'hFFFFFFF1)));
    issue16(-16'sd32768, -16'sd32768);  wait16("min x min");
    chk("min x min literal", bus16.product, 64'(32'h40000000));
    issue16(-16'sd32768, 16'sd32767);   wait16("min x max");
    issue16(16'sd0, -16'sd1);           wait16("0 x -1");
    issue16(16'sd32767, 16'sd32767);    wait16("max x max");

    // Busy guard then back-to-back issue from the done cycle
    issue16(16'sd7, 16'sd6);
    repeat (4) @(negedge clk);
    bus16.op_a = 16'sd100; bus16.op_b = 16'sd100; bus16.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    wait16("guard 7x6");
    d1 = cyc;
    issue16(16'sd100, 16'sd100);
    wait16("b2b 100x100");
    chk("b2b gap", 64'(cyc - d1), 64'(17));

`ifdef MUL_ACCUM_EN
    bus16.acc_add = 1'b0; issue16(16'sd100, 16'sd200); wait16("acc1");
    chk("acc overwrite", bus16.acc, 64'(20000));
    bus16.acc_add = 1'b1; issue16(-16'sd300, 16'sd2); wait16("acc2");
    chk("acc add", bus16.acc, 64'(19400));
    bus16.acc_add = 1'b0; issue16(16'sd5, 16'sd5); wait16("acc3");
    chk("acc restart", bus16.acc, 64'(25));
`endif

    // Asynchronous reset mid-run
    issue16(16'sd1234, -16'sd77);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async busy", 64'(bus16.busy), 64'(0));
    chk("async done", 64'(bus16.done), 64'(0));
    chk("async product", bus16.product, 64'(0));
`ifdef MUL_ACCUM_EN
    chk("async acc", bus16.acc, 64'(0));
`endif
    exp16_q.delete();
    t16_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus16.done === 1'b1) seen = 1;
    end
    chk("no done after rst", 64'(seen), 64'(0));
    issue16(-16'sd9, 16'sd11); wait16("post-rst op");

    // WIDTH=4 sweep
    for (int k = 0; k < 1000; k++) begin
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      bus4.op_a = a4; bus4.op_b = b4; bus4.start = 1'b1;
      exp4_q.push_back(8'(int'(a4) * int'(b4)));
      t = cyc + 1;
      @(negedge clk);
      bus4.start = 1'b0;
      for (int i = 0; i < 20 && bus4.done !== 1'b1; i++) @(negedge clk);
      chk("w4 done", 64'(bus4.done), 64'(1));
      chk("w4 latency", 64'(cyc - t), 64'(4));
      chk("w4 product", bus4.product, exp4_q.pop_front());
    end

    // WIDTH=32 sweep
    for (int k = 0; k < 1000; k++) begin
      a32 = $urandom;
      b32 = $urandom;
      if (k == 0) begin a32 = 32'sh80000000; b32 = 32'sh80000000; end
      bus32.op_a = a32; bus32.op_b = b32; bus32.start = 1'b1;
      exp32_q.push_back(longint'(a32) * longint'(b32));
      t = cyc + 1;
      @(negedge clk);
      bus32.start = 1'b0;
      for (int i = 0; i < 50 && bus32.done !== 1'b1; i++) @(negedge clk);
      chk("w32 done", 64'(bus32.done), 64'(1));
      chk("w32 latency", 64'(cyc - t), 64'(32));
      chk("w32 product", bus32.product, exp32_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential signed multiplier for the QOA decoder datapath, used by the LMS predictor to form history × weight products. Radix-2 Booth, one partial-product step per clock, with a start/busy/done handshake so the decoder FSM can issue back-to-back multiplies. Optionally accumulates successive products, giving a full dot-product engine with no external adder.

## Interface
- `WIDTH`, 16: operand width in bits, signed two's complement; legal range 4..32.
- `ACC_GUARD`, 4: extra accumulator MSBs above 2*WIDTH. Used only with `MUL_ACCUM_EN`.

- `clk`: input, 1 bit. Single clock; all state updates on its rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `start`: input, 1 bit. Request a multiply; accepted only when `busy`=0.
- `op_a`: input, WIDTH bits, signed. Multiplicand; sampled at acceptance.
- `op_b`: input, WIDTH bits, signed. Multiplier; sampled at acceptance.
- `busy`: output, 1 bit. High while a multiply is in progress.
- `done`: output, 1 bit. One-cycle pulse when `product` becomes valid.
- `product`: output, 2*WIDTH bits, signed. Last completed product; held until the next completion.
- `acc_add`: input, 1 bit (`MUL_ACCUM_EN` only). Sampled with `start`. 1 = add the product to the accumulator; 0 = overwrite the accumulator.
- `acc`: output, 2*WIDTH+ACC_GUARD bits, signed (`MUL_ACCUM_EN` only). Accumulator value.

## Operation
- States: IDLE, RUN, DONE. The state encoding is internal.
- IDLE:
  - `start`=1 latches `op_a`, `op_b` (and `acc_add` when the accumulator is compiled in).
  - Clears the partial product and the Booth bit q(-1).
  - Sets the step counter to WIDTH and goes to RUN.
- RUN:
  - Each cycle examines {q0, q(-1)}: 01 adds A, 10 subtracts A, 00/11 do nothing.
  - Then performs an arithmetic right shift of the {partial, Q, q(-1)} register and decrements the counter.
  - The upper partial register is WIDTH+1 bits wide, so A = -2^(WIDTH-1) never overflows.
  - When the counter reaches 1, the final step completes, `product` loads, and the state goes to DONE.
- DONE:
  - `done`=1 and `busy`=0 for exactly one cycle.
  - The state then returns to IDLE, unless `start`=1 in this cycle. In that case the new operands are accepted and the state goes straight to RUN (back-to-back issue).
- `start` while `busy`=1 is ignored: it is not queued and the operands are not resampled.
- Result is exact for all operand pairs. Example: (-2^(W-1))·(-2^(W-1)) = 2^(2W-2), which fits in 2*WIDTH signed bits.
- Reset (asynchronous, any state, including mid-RUN) forces the following; the in-flight operation is discarded with no `done`:
  - state = IDLE
  - `busy` = 0, `done` = 0
  - `product` = 0
  - `acc` = 0
  - counter and internal registers = 0

## Timing
- Acceptance: `start`=1 and `busy`=0 at rising edge E0.
- `busy`=1 from E0 through the edge E(WIDTH).
- `done` and `product` are valid in the cycle following edge E(WIDTH). Latency is WIDTH cycles from acceptance to `done`.
- Maximum throughput is one product per WIDTH+1 cycles. This is reached when `start` is held high or re-asserted during the `done` cycle.
- `acc` updates on the same edge as `product` and is visible in the `done` cycle.
- Reset values are listed under Operation; all outputs are 0 in reset.

## Configuration
- `MUL_ACCUM_EN` defined:
  - Adds the `acc_add` input and the `acc` output, plus an accumulator register of 2*WIDTH+ACC_GUARD bits.
  - On completion, `acc` = (`acc_add` ? `acc` : 0) + sign-extended `product`.
  - Wraps modulo 2^(2*WIDTH+ACC_GUARD); there is no saturation.
- `MUL_ACCUM_EN` undefined:
  - Ports and register are absent; `ACC_GUARD` is ignored.
  - Behaviour of `product`, `done` and `busy` is identical to the accumulator build.

## Test plan
- Reset release, WIDTH=16: all outputs 0. Then `op_a`=3, `op_b`=-5, `start` pulse → `done` exactly 16 cycles after acceptance, `product`=-15 (0xFFFFFFF1), `busy` low in the `done` cycle.
- Corner operands, WIDTH=16:
  - -32768 × -32768 → 0x40000000
  - -32768 × 32767 → 0xC0008000
  - 0 × -1 → 0
  - 32767 × 32767 → 0x3FFF0001
- Busy guard and back-to-back issue:
  - Issue 7×6, then pulse `start` with 100×100 mid-RUN → ignored; `product`=42.
  - `start` re-asserted in the `done` cycle with 100×100 → accepted; second `done` 17 cycles after the first, `product`=10000.
- Async reset: assert `rst_n`=0 eight cycles into a multiply, mid-cycle → all outputs 0 immediately. After release no `done` appears, and a new start completes normally.
- `MUL_ACCUM_EN` build:
  - 100×200 with `acc_add`=0 → `acc`=20000.
  - -300×2 with `acc_add`=1 → `acc`=19400.
  - 5×5 with `acc_add`=0 → `acc`=25.
- Parameter sweep, WIDTH=4 and WIDTH=32: random signed operands against a reference model, 1000 operations each. Latency must equal WIDTH every time.
